// File: rtl/csi_rx_pkg.sv
// Shared CSI-2 receive definitions: packet-type threshold, header FSM
// states and the header ECC column table (one 6-bit column per data bit).
package csi_rx_pkg;

    // Data types at or above this value are long packets carrying a payload.
    localparam logic [5:0] DT_LONG_MIN = 6'h10;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PAYLOAD = 2'd1,
        ST_DISCARD = 2'd2
    } rx_state_t;

    // ECC contribution of header data bit k. Every column has odd weight (3 or 5),
    // so a single-bit data error never aliases a single-bit ECC error and any
    // double error yields an even-weight syndrome that matches nothing.
    localparam logic [5:0] ECC_COL [0:23] = '{
        6'h07, 6'h0B, 6'h0D, 6'h0E, 6'h13, 6'h15, 6'h16, 6'h19,
        6'h1A, 6'h1C, 6'h23, 6'h25, 6'h26, 6'h29, 6'h2A, 6'h2C,
        6'h31, 6'h32, 6'h34, 6'h38, 6'h1F, 6'h2F, 6'h37, 6'h3B
    };

endpackage

// File: rtl/csi_rx_hdr_ecc.sv
// CSI-2 packet header ECC generator: 24 header data bits in, 8-bit ECC out
// (the two top ECC bits are always zero).
module csi_rx_hdr_ecc
    import csi_rx_pkg::*;
(
    input  logic [23:0] data,
    output logic [7:0]  ecc
);

    // XOR together the table column of every data bit that is set.
    always_comb begin
        ecc = 8'h00;
        for (int k = 0; k < 24; k++) begin
            if (data[k]) begin
                ecc[5:0] = ecc[5:0] ^ ECC_COL[k];
            end
        end
    end

endmodule

// File: rtl/csi_rx_hdr_ctrl.sv
// CSI-2 receive header controller: two-stage pipeline that checks and
// corrects packet headers, tracks the payload length of long packets,
// forwards payload words and counts corrected/uncorrectable headers.
module csi_rx_hdr_ctrl
    import csi_rx_pkg::*;
(
    input  logic        clk,
    input  logic        srst_n,
    input  logic        in_valid,
    input  logic        in_sof,
    input  logic [31:0] in_data,
    input  logic        cnt_clr,
    output logic        hdr_valid,
    output logic [1:0]  hdr_vc,
    output logic [5:0]  hdr_dt,
    output logic [15:0] hdr_wc,
    output logic        hdr_corrected,
    output logic        hdr_err,
    output logic        trunc_err,
    output logic        pl_valid,
    output logic [31:0] pl_data,
    output logic        pl_last,
    output logic [15:0] corr_cnt,
    output logic [15:0] uncorr_cnt
);

    logic        s1_valid;
    logic        s1_sof;
    logic [31:0] s1_data;
    logic [7:0]  ecc_calc;
    logic [5:0]  syndrome;
    logic [23:0] fixed_hdr;
    logic        hdr_ok;
    logic        hdr_fix;
    logic [16:0] rem_calc;
    logic        corr_evt;
    logic        uncorr_evt;
    logic        unused_bits;
    rx_state_t   state;
    logic [15:0] remaining;

    csi_rx_hdr_ecc u_ecc (
        .data (s1_data[23:0]),
        .ecc  (ecc_calc)
    );

    assign syndrome    = ecc_calc[5:0] ^ s1_data[29:24];
    assign unused_bits = ^{ecc_calc[7:6], s1_data[31:30]};

    // Payload words to expect = ceil((WC + 2 CRC bytes) / 4), done in 17 bits.
    assign rem_calc = {1'b0, fixed_hdr[23:8]} + 17'd5;

    assign corr_evt   = s1_valid & s1_sof & hdr_ok & hdr_fix;
    assign uncorr_evt = s1_valid & s1_sof & ~hdr_ok;

    // Classify the stage-1 syndrome and repair a single flipped data bit.
    always_comb begin
        fixed_hdr = s1_data[23:0];
        hdr_ok    = 1'b0;
        hdr_fix   = 1'b0;
        if (syndrome == 6'd0) begin
            hdr_ok = 1'b1;
        end else if ($onehot(syndrome)) begin
            hdr_ok  = 1'b1;
            hdr_fix = 1'b1;
        end else begin
            for (int k = 0; k < 24; k++) begin
                if (syndrome == ECC_COL[k]) begin
                    fixed_hdr[k] = ~s1_data[k];
                    hdr_ok       = 1'b1;
                    hdr_fix      = 1'b1;
                end
            end
        end
    end

    // Stage 1: register the incoming word unchanged.
    always_ff @(posedge clk) begin
        if (!srst_n) begin
            s1_valid <= 1'b0;
            s1_sof   <= 1'b0;
            s1_data  <= 32'h0;
        end else begin
            s1_valid <= in_valid;
            s1_sof   <= in_sof;
            s1_data  <= in_data;
        end
    end

    // Stage 2: packet FSM and registered outputs; a header always wins over payload.
    always_ff @(posedge clk) begin
        if (!srst_n) begin
            state         <= ST_IDLE;
            remaining     <= 16'h0;
            hdr_valid     <= 1'b0;
            hdr_vc        <= 2'h0;
            hdr_dt        <= 6'h0;
            hdr_wc        <= 16'h0;
            hdr_corrected <= 1'b0;
            hdr_err       <= 1'b0;
            trunc_err     <= 1'b0;
            pl_valid      <= 1'b0;
            pl_data       <= 32'h0;
            pl_last       <= 1'b0;
        end else begin
            hdr_valid     <= 1'b0;
            hdr_corrected <= 1'b0;
            hdr_err       <= 1'b0;
            trunc_err     <= 1'b0;
            pl_valid      <= 1'b0;
            pl_last       <= 1'b0;
            if (s1_valid) begin
                if (s1_sof) begin
                    trunc_err <= (state == ST_PAYLOAD);
                    if (hdr_ok) begin
                        hdr_valid     <= 1'b1;
                        hdr_corrected <= hdr_fix;
                        hdr_vc        <= fixed_hdr[7:6];
                        hdr_dt        <= fixed_hdr[5:0];
                        hdr_wc        <= fixed_hdr[23:8];
                        if (fixed_hdr[5:0] >= DT_LONG_MIN) begin
                            remaining <= {1'b0, rem_calc[16:2]};
                            state     <= ST_PAYLOAD;
                        end else begin
                            remaining <= 16'h0;
                            state     <= ST_IDLE;
                        end
                    end else begin
                        hdr_err   <= 1'b1;
                        remaining <= 16'h0;
                        state     <= ST_DISCARD;
                    end
                end else if (state == ST_PAYLOAD) begin
                    pl_valid  <= 1'b1;
                    pl_data   <= s1_data;
                    remaining <= remaining - 16'd1;
                    if (remaining == 16'd1) begin
                        pl_last <= 1'b1;
                        state   <= ST_IDLE;
                    end
                end
            end
        end
    end

    // Saturating header error counters; a clear beats a same-cycle increment.
    always_ff @(posedge clk) begin
        if (!srst_n || cnt_clr) begin
            corr_cnt   <= 16'h0;
            uncorr_cnt <= 16'h0;
        end else begin
            if (corr_evt && corr_cnt != 16'hFFFF) begin
                corr_cnt <= corr_cnt + 16'd1;
            end
            if (uncorr_evt && uncorr_cnt != 16'hFFFF) begin
                uncorr_cnt <= uncorr_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_csi_rx_hdr_ctrl.sv
// Self-checking bench for csi_rx_hdr_ctrl: directed packet scenarios plus a
// randomized stream, checked against a packet-level reference model through
// a cycle-stamped scoreboard.
module tb_csi_rx_hdr_ctrl;

    logic        clk = 1'b0;
    logic        srst_n;
    logic        in_valid;
    logic        in_sof;
    logic [31:0] in_data;
    logic        cnt_clr;
    logic        hdr_valid;
    logic [1:0]  hdr_vc;
    logic [5:0]  hdr_dt;
    logic [15:0] hdr_wc;
    logic        hdr_corrected;
    logic        hdr_err;
    logic        trunc_err;
    logic        pl_valid;
    logic [31:0] pl_data;
    logic        pl_last;
    logic [15:0] corr_cnt;
    logic [15:0] uncorr_cnt;

    typedef struct {
        int          cyc;
        logic        hv;
        logic [1:0]  vc;
        logic [5:0]  dt;
        logic [15:0] wc;
        logic        corr;
        logic        herr;
        logic        terr;
        logic        pv;
        logic [31:0] pd;
        logic        pl;
    } exp_t;

    localparam int M_IDLE    = 0;
    localparam int M_PAYLOAD = 1;
    localparam int M_DISCARD = 2;

    exp_t sb[$];
    exp_t mon_e;
    int   cyc      = 0;
    int   tests    = 0;
    int   fails    = 0;
    int   m_mode   = M_IDLE;
    int   m_rem    = 0;
    int   m_corr   = 0;
    int   m_uncorr = 0;

    csi_rx_hdr_ctrl dut (
        .clk           (clk),
        .srst_n        (srst_n),
        .in_valid      (in_valid),
        .in_sof        (in_sof),
        .in_data       (in_data),
        .cnt_clr       (cnt_clr),
        .hdr_valid     (hdr_valid),
        .hdr_vc        (hdr_vc),
        .hdr_dt        (hdr_dt),
        .hdr_wc        (hdr_wc),
        .hdr_corrected (hdr_corrected),
        .hdr_err       (hdr_err),
        .trunc_err     (trunc_err),
        .pl_valid      (pl_valid),
        .pl_data       (pl_data),
        .pl_last       (pl_last),
        .corr_cnt      (corr_cnt),
        .uncorr_cnt    (uncorr_cnt)
    );

    // Free-running clock and cycle stamp.
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // CSI-2 header parity equations written out bit by bit.
    function automatic logic [5:0] ref_ecc(input logic [23:0] d);
        logic [5:0] p;
        p[0] = d[0]^d[1]^d[2]^d[4]^d[5]^d[7]^d[10]^d[11]^d[13]^d[16]^d[20]^d[21]^d[22]^d[23];
        p[1] = d[0]^d[1]^d[3]^d[4]^d[6]^d[8]^d[10]^d[12]^d[14]^d[17]^d[20]^d[21]^d[22]^d[23];
        p[2] = d[0]^d[2]^d[3]^d[5]^d[6]^d[9]^d[11]^d[12]^d[15]^d[18]^d[20]^d[21]^d[22];
        p[3] = d[1]^d[2]^d[3]^d[7]^d[8]^d[9]^d[13]^d[14]^d[15]^d[19]^d[20]^d[21]^d[23];
        p[4] = d[4]^d[5]^d[6]^d[7]^d[8]^d[9]^d[16]^d[17]^d[18]^d[19]^d[20]^d[22]^d[23];
        p[5] = d[10]^d[11]^d[12]^d[13]^d[14]^d[15]^d[16]^d[17]^d[18]^d[19]^d[21]^d[22]^d[23];
        return p;
    endfunction

    function automatic logic [31:0] make_hdr(input logic [1:0] vc, input logic [5:0] dt,
                                             input logic [15:0] wc, input logic [1:0] top);
        logic [23:0] d;
        d = {wc, vc, dt};
        return {top, ref_ecc(d), d};
    endfunction

    // Decode by trial: which single data bit would explain the syndrome?
    function automatic void ref_decode(input logic [31:0] w, output logic ok,
                                       output logic fix, output logic [23:0] d);
        logic [5:0] syn;
        d   = w[23:0];
        syn = ref_ecc(w[23:0]) ^ w[29:24];
        ok  = 1'b0;
        fix = 1'b0;
        if (syn == 6'd0) begin
            ok = 1'b1;
        end else if ($countones(syn) == 1) begin
            ok  = 1'b1;
            fix = 1'b1;
        end else begin
            for (int k = 0; k < 24; k++) begin
                if (ref_ecc(24'h1 << k) == syn) begin
                    d[k] = ~d[k];
                    ok   = 1'b1;
                    fix  = 1'b1;
                end
            end
        end
    endfunction

    // Reference model: one call per issued cycle; the response is due two cycles later.
    task automatic model_step(input logic v, input logic s, input logic [31:0] w,
                              input logic clr, input int c);
        exp_t        e;
        logic        ok;
        logic        fix;
        logic [23:0] d;
        bit          emit;
        if (clr) begin
            m_corr   = 0;
            m_uncorr = 0;
        end
        if (!v) return;
        e    = '{cyc: c + 2, hv: 0, vc: 0, dt: 0, wc: 0, corr: 0, herr: 0,
                 terr: 0, pv: 0, pd: 0, pl: 0};
        emit = 0;
        if (s) begin
            emit   = 1;
            e.terr = (m_mode == M_PAYLOAD);
            ref_decode(w, ok, fix, d);
            if (ok) begin
                e.hv   = 1;
                e.corr = fix;
                e.vc   = d[7:6];
                e.dt   = d[5:0];
                e.wc   = d[23:8];
                if (fix && m_corr < 65535) m_corr++;
                if (int'(d[5:0]) >= 16) begin
                    m_rem  = (int'(d[23:8]) + 2 + 3) / 4;
                    m_mode = M_PAYLOAD;
                end else begin
                    m_mode = M_IDLE;
                end
            end else begin
                e.herr = 1;
                if (m_uncorr < 65535) m_uncorr++;
                m_mode = M_DISCARD;
            end
        end else if (m_mode == M_PAYLOAD) begin
            emit = 1;
            e.pv = 1;
            e.pd = w;
            if (m_rem == 1) begin
                e.pl   = 1;
                m_mode = M_IDLE;
            end
            m_rem--;
        end
        if (emit) sb.push_back(e);
    endtask

    task automatic apply_stimulus(input logic v, input logic s, input logic [31:0] w,
                                  input logic clr);
        @(posedge clk);
        #1;
        in_valid = v;
        in_sof   = s;
        in_data  = w;
        cnt_clr  = clr;
        model_step(v, s, w, clr, cyc);
    endtask

    task automatic check_output(input string name, input logic [31:0] act,
                                input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("[TB] FAIL %s: actual 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    task automatic drain();
        apply_stimulus(0, 0, 32'h0, 0);
        repeat (4) @(negedge clk);
        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("[TB] FAIL drain: actual %0d pending events, required 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic check_counters(input string tag);
        check_output({tag, "_corr_cnt"}, {16'h0, corr_cnt}, m_corr);
        check_output({tag, "_uncorr_cnt"}, {16'h0, uncorr_cnt}, m_uncorr);
    endtask

    // One-cycle reset pulse; responses not yet out of the pipeline are lost.
    task automatic pulse_reset();
        @(posedge clk);
        #1;
        srst_n   = 1'b0;
        in_valid = 1'b0;
        in_sof   = 1'b0;
        cnt_clr  = 1'b0;
        while (sb.size() > 0 && sb[$].cyc > cyc) void'(sb.pop_back());
        m_mode   = M_IDLE;
        m_rem    = 0;
        m_corr   = 0;
        m_uncorr = 0;
        @(posedge clk);
        @(negedge clk);
        check_output("rst_hdr_valid", {31'h0, hdr_valid}, 0);
        check_output("rst_pl_valid", {31'h0, pl_valid}, 0);
        check_output("rst_pl_data", pl_data, 0);
        check_output("rst_hdr_wc", {16'h0, hdr_wc}, 0);
        check_counters("rst");
        srst_n = 1'b1;
    endtask

    // Scoreboard monitor: every due expectation is compared, every stray output is flagged.
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].cyc < cyc) begin
            mon_e = sb.pop_front();
            tests++;
            fails++;
            $display("[TB] FAIL missed_output: actual none at cycle %0d, required event", mon_e.cyc);
        end
        if (sb.size() > 0 && sb[0].cyc == cyc) begin
            mon_e = sb.pop_front();
            tests++;
            if (hdr_valid !== mon_e.hv || hdr_err !== mon_e.herr || trunc_err !== mon_e.terr ||
                pl_valid !== mon_e.pv || pl_last !== mon_e.pl ||
                (mon_e.hv && (hdr_vc !== mon_e.vc || hdr_dt !== mon_e.dt ||
                              hdr_wc !== mon_e.wc || hdr_corrected !== mon_e.corr)) ||
                (mon_e.pv && pl_data !== mon_e.pd)) begin
                fails++;
                $display("[TB] FAIL output_cycle_%0d: actual hv=%0b vc=%0h dt=%0h wc=%0h corr=%0b herr=%0b terr=%0b pv=%0b pd=%0h pl=%0b, required hv=%0b vc=%0h dt=%0h wc=%0h corr=%0b herr=%0b terr=%0b pv=%0b pd=%0h pl=%0b",
                         cyc, hdr_valid, hdr_vc, hdr_dt, hdr_wc, hdr_corrected, hdr_err,
                         trunc_err, pl_valid, pl_data, pl_last, mon_e.hv, mon_e.vc, mon_e.dt,
                         mon_e.wc, mon_e.corr, mon_e.herr, mon_e.terr, mon_e.pv, mon_e.pd, mon_e.pl);
            end
        end else if (hdr_valid === 1'b1 || hdr_err === 1'b1 || trunc_err === 1'b1 ||
                     pl_valid === 1'b1) begin
            tests++;
            fails++;
            $display("[TB] FAIL unexpected_output cycle %0d: actual hv=%0b herr=%0b terr=%0b pv=%0b, required no output",
                     cyc, hdr_valid, hdr_err, trunc_err, pl_valid);
        end
    end

    // Directed scenarios followed by a randomized packet stream.
    initial begin
        logic [31:0] hdr;
        logic [31:0] w;
        logic [1:0]  vc;
        logic [5:0]  dt;
        logic [15:0] wc;
        int          r;
        int          b1;
        int          b2;

        srst_n   = 1'b0;
        in_valid = 1'b0;
        in_sof   = 1'b0;
        in_data  = 32'h0;
        cnt_clr  = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_output("init_hdr_valid", {31'h0, hdr_valid}, 0);
        check_output("init_hdr_err", {31'h0, hdr_err}, 0);
        check_output("init_trunc_err", {31'h0, trunc_err}, 0);
        check_output("init_pl_valid", {31'h0, pl_valid}, 0);
        check_output("init_pl_last", {31'h0, pl_last}, 0);
        check_counters("init");
        srst_n = 1'b1;

        // Clean long packet: 16 bytes + CRC -> 5 words.
        hdr = make_hdr(2'd0, 6'h2B, 16'h0010, 2'd0);
        apply_stimulus(1, 1, hdr, 0);
        for (int i = 0; i < 5; i++) apply_stimulus(1, 0, $urandom, 0);
        drain();

        // Single data-bit error in the word count.
        apply_stimulus(1, 1, hdr ^ 32'h0000_1000, 0);
        for (int i = 0; i < 5; i++) apply_stimulus(1, 0, $urandom, 0);
        drain();
        check_counters("single_err");
        check_output("single_err_corr_cnt_is_1", {16'h0, corr_cnt}, 1);

        // Double error: header dropped, payload discarded, next short header accepted.
        apply_stimulus(1, 1, hdr ^ 32'h0002_0008, 0);
        for (int i = 0; i < 5; i++) apply_stimulus(1, 0, $urandom, 0);
        apply_stimulus(1, 1, make_hdr(2'd1, 6'h00, 16'h1234, 2'd0), 0);
        drain();
        check_counters("double_err");
        check_output("double_err_uncorr_cnt_is_1", {16'h0, uncorr_cnt}, 1);

        // Truncated packet, new long header decoded in the same cycle.
        apply_stimulus(1, 1, hdr, 0);
        apply_stimulus(1, 0, $urandom, 0);
        apply_stimulus(1, 0, $urandom, 0);
        apply_stimulus(1, 1, make_hdr(2'd2, 6'h24, 16'h0004, 2'd0), 0);
        apply_stimulus(1, 0, $urandom, 0);
        apply_stimulus(0, 0, 32'h0, 0);
        apply_stimulus(1, 0, $urandom, 0);
        drain();

        // Zero word count: only the CRC word.
        apply_stimulus(1, 1, make_hdr(2'd3, 6'h12, 16'h0000, 2'd0), 0);
        apply_stimulus(1, 0, 32'hCAFE_F00D, 0);
        apply_stimulus(1, 0, 32'h1111_2222, 0);
        drain();

        // Reset mid-payload, then stray words and a fresh short header.
        apply_stimulus(1, 1, make_hdr(2'd0, 6'h2A, 16'h0020, 2'd0), 0);
        for (int i = 0; i < 3; i++) apply_stimulus(1, 0, $urandom, 0);
        pulse_reset();
        for (int i = 0; i < 4; i++) apply_stimulus(1, 0, $urandom, 0);
        apply_stimulus(1, 1, make_hdr(2'd1, 6'h01, 16'h0040, 2'd0), 0);
        drain();

        // Clear coinciding with a correction.
        apply_stimulus(1, 1, make_hdr(2'd0, 6'h05, 16'h0007, 2'd0) ^ 32'h0000_0004, 0);
        apply_stimulus(0, 0, 32'h0, 1);
        drain();
        check_counters("clr_with_inc");
        check_output("clr_with_inc_corr_cnt_is_0", {16'h0, corr_cnt}, 0);

        // Random stream: headers with 0/1/2 bit errors, payload, junk, gaps, clears.
        for (int n = 0; n < 600; n++) begin
            r = $urandom_range(0, 99);
            if (r < 18) begin
                apply_stimulus(0, 0, $urandom, ($urandom_range(0, 29) == 0));
            end else if (r < 34) begin
                vc  = 2'($urandom_range(0, 3));
                dt  = ($urandom_range(0, 1) == 1) ? 6'($urandom_range(16, 63))
                                                  : 6'($urandom_range(0, 15));
                wc  = 16'($urandom_range(0, 40));
                w   = make_hdr(vc, dt, wc, 2'($urandom_range(0, 3)));
                r   = $urandom_range(0, 9);
                b1  = $urandom_range(0, 29);
                b2  = (b1 + $urandom_range(1, 29)) % 30;
                if (r == 6 || r == 7) w = w ^ (32'h1 << b1);
                else if (r == 8) w = w ^ (32'h1 << b1) ^ (32'h1 << b2);
                apply_stimulus(1, 1, w, ($urandom_range(0, 29) == 0));
            end else begin
                apply_stimulus(1, 0, $urandom, ($urandom_range(0, 29) == 0));
            end
        end
        drain();
        check_counters("random_end");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
